ac_char_feeder: RTL

Upstream sequencer for the Aho-Corasick table reader. Accepts a byte stream of text with a valid/ready handshake, buffers it in a small FIFO, and splits each byte into two 4-bit symbols, high nibble first. It presents one symbol at a time to the table reader, holds the current automaton state in a register that drives the reader's state input, and captures the reader's next state. Each step is reported downstream with the captured state, the match flag and the symbol position.

---
 rtl/ac_pkg.sv | 24 ++
 rtl/ac_byte_fifo.sv | 49 ++++
 rtl/ac_char_feeder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ac_pkg.sv
// Shared types and constants for the Aho-Corasick character feeder.
package ac_pkg;

  localparam int unsigned STATE_W    = 8;
  localparam int unsigned SYM_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ENTRY_W    = BYTE_W + 1;
  localparam int unsigned ROOT_STATE = 0;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ISSUE_HI,
    CAP_HI,
    ISSUE_LO,
    CAP_LO
  } fsm_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/ac_byte_fifo.sv
// DEPTH x WIDTH synchronous FIFO with show-ahead head and full/empty flags.
module ac_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ac_char_feeder.sv
// Splits buffered text bytes into nibble symbols for the AC table reader
// and reports each step's next state, hit flag and symbol position.
module ac_char_feeder #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STATE_W = ac_pkg::STATE_W,
  parameter int unsigned POS_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [7:0]         IN_DATA,
  input  logic               IN_LAST,
  output logic               IN_READY,
  output logic               INITIALIZE,
  output logic               EN,
  output logic [3:0]         STRING,
  output logic [STATE_W-1:0] NOW_STATE_IN,
  input  logic [STATE_W-1:0] NOW_STATE_OUT,
  input  logic               EN_MATCH,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [STATE_W-1:0] RES_STATE,
  output logic               RES_HIT,
  output logic [POS_W-1:0]   RES_POS,
  output logic               RES_LAST
);

  import ac_pkg::*;

  fsm_t                state, state_nx;
  entry_t              head;
  logic                full, empty;
  logic                ready_q;
  logic                pop, cap, can_cap;
  logic [BYTE_W-1:0]   byte_q, byte_nx;
  logic                last_q;
  logic                sot;
  logic [STATE_W-1:0]  st_q;
  logic [POS_W-1:0]    pos;
  logic                en_nx, init_nx;
  logic [SYM_W-1:0]    sym_nx;

  assign IN_READY     = ready_q && !full;
  assign NOW_STATE_IN = st_q;
  assign can_cap      = !RES_VALID || RES_READY;

  ac_byte_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (IN_VALID && IN_READY),
    .pop   (pop),
    .din   ({IN_LAST, IN_DATA}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, pop/capture strobes and the next values of the registered outputs.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    cap      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = sot ? INIT : ISSUE_HI;
        end
      end
      INIT:     state_nx = ISSUE_HI;
      ISSUE_HI: state_nx = CAP_HI;
      CAP_HI: begin
        if (can_cap) begin
          cap      = 1'b1;
          state_nx = ISSUE_LO;
        end
      end
      ISSUE_LO: state_nx = CAP_LO;
      CAP_LO: begin
        if (can_cap) begin
          cap = 1'b1;
          if (!last_q && !empty) begin
            pop      = 1'b1;
            state_nx = ISSUE_HI;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    byte_nx = pop ? head.data : byte_q;
    en_nx   = state_nx inside {ISSUE_HI, CAP_HI, ISSUE_LO, CAP_LO};
    init_nx = (state_nx == INIT);
    if (state_nx inside {ISSUE_HI, CAP_HI})      sym_nx = byte_nx[7:4];
    else if (state_nx inside {ISSUE_LO, CAP_LO}) sym_nx = byte_nx[3:0];
    else                                          sym_nx = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q    <= 1'b0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      sot        <= 1'b1;
      st_q       <= STATE_W'(ROOT_STATE);
      pos        <= '0;
      EN         <= 1'b0;
      STRING     <= '0;
      INITIALIZE <= 1'b0;
      RES_VALID  <= 1'b0;
      RES_STATE  <= '0;
      RES_HIT    <= 1'b0;
      RES_POS    <= '0;
      RES_LAST   <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      EN         <= en_nx;
      STRING     <= sym_nx;
      INITIALIZE <= init_nx;
      if (pop) begin
        byte_q <= head.data;
        last_q <= head.last;
      end
      if (state == INIT) begin
        st_q <= STATE_W'(ROOT_STATE);
        sot  <= 1'b0;
      end
      if (cap) begin
        RES_VALID <= 1'b1;
        RES_STATE <= NOW_STATE_OUT;
        RES_HIT   <= EN_MATCH;
        RES_POS   <= pos;
        RES_LAST  <= last_q && (state == CAP_LO);
        // Closing the final byte of a text rewinds for the next one.
        if (last_q && (state == CAP_LO)) begin
          st_q <= STATE_W'(ROOT_STATE);
          pos  <= '0;
          sot  <= 1'b1;
        end else begin
          st_q <= NOW_STATE_OUT;
          pos  <= pos + POS_W'(1);
        end
      end else if (RES_READY) begin
        RES_VALID <= 1'b0;
      end
    end
  end

endmodule
